// File: rtl/fp_pkg.sv
// Shared constants, FSM state type and IEEE-754 single-precision field helpers.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int INF_EXP = 255;
  localparam logic [EXP_W+MAN_W:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } fsm_state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Split a raw 32-bit word into its IEEE fields.
  function automatic fp32_t to_fp(input logic [EXP_W+MAN_W:0] x);
    return fp32_t'(x);
  endfunction

  // Exponent zero counts as zero: denormals are flushed.
  function automatic logic is_zero(input logic [EXP_W-1:0] e);
    return (e == '0);
  endfunction

  function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    return (e == '1) && (m == '0);
  endfunction

  function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    return (e == '1) && (m != '0);
  endfunction

endpackage

// File: rtl/mant_div_core.sv
// Restoring significand divider producing one quotient bit per step, MSB first.
// Latency: 25 steps after load; done_o flags the final step.
// Backpressure: none; the caller gates stepping with start_i.
module mant_div_core
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             start_i,
  input  logic [MAN_W:0]   ma_i,
  input  logic [MAN_W:0]   mb_i,
  output logic             done_o,
  output logic [MAN_W+1:0] quo_o
);

  localparam int QW = MAN_W + 2;
  localparam logic [4:0] LAST_ITER = 5'(QW - 1);

  logic [QW-1:0]  rem_q, rem_d;
  logic [QW-1:0]  quo_q, quo_d;
  logic [MAN_W:0] mb_q, mb_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [QW-1:0]  diff;
  logic           ge;

  // One restoring step: trial subtract, keep it if non-negative, shift remainder.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    mb_d  = mb_q;
    cnt_d = cnt_q;
    diff  = rem_q - {1'b0, mb_q};
    ge    = (rem_q >= {1'b0, mb_q});
    if (load_i) begin
      rem_d = {1'b0, ma_i};
      mb_d  = mb_i;
      quo_d = '0;
      cnt_d = '0;
    end else if (start_i) begin
      quo_d = {quo_q[QW-2:0], ge};
      rem_d = (ge ? diff : rem_q) << 1;
      cnt_d = cnt_q + 5'd1;
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      mb_q  <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      mb_q  <= mb_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = start_i && (cnt_q == LAST_ITER);
  assign quo_o  = quo_q;

endmodule

// File: rtl/fp_divider.sv
// Iterative IEEE-754 single divider q = a / b, truncating, denormals flushed to zero.
// Latency: out_valid 27 cycles after a normal accept, 1 cycle after a special-case accept.
// Backpressure: result and flags held in DONE until out_ready; in_ready low whenever busy.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  fsm_state_e        state_q, state_d;
  logic [31:0]       q_q, q_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;

  fp32_t             fa, fb;
  logic              accept;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              core_done;
  logic [MAN_W+1:0]  core_quo;
  logic signed [9:0] exp_n;
  logic [MAN_W-1:0]  man_n;

  assign fa     = to_fp(a);
  assign fb     = to_fp(b);
  assign a_zero = is_zero(fa.expo);
  assign b_zero = is_zero(fb.expo);
  assign a_inf  = is_inf(fa.expo, fa.man);
  assign b_inf  = is_inf(fb.expo, fb.man);
  assign a_nan  = is_nan(fa.expo, fa.man);
  assign b_nan  = is_nan(fb.expo, fb.man);

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);

  // The core is loaded on every accept; it only steps while in DIVIDE.
  mant_div_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .start_i (state_q == S_DIVIDE),
    .ma_i    ({1'b1, fa.man}),
    .mb_i    ({1'b1, fb.man}),
    .done_o  (core_done),
    .quo_o   (core_quo)
  );

  // Normalise the quotient: a leading zero means the quotient lies in [0.5,1).
  always_comb begin
    if (core_quo[MAN_W+1]) begin
      exp_n = exp_q;
      man_n = core_quo[MAN_W:1];
    end else begin
      exp_n = exp_q - 10'sd1;
      man_n = core_quo[MAN_W-1:0];
    end
  end

  // Next-state and datapath decode: specials resolve at accept, normal path packs in NORM.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_d  = fa.sign ^ fb.sign;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            q_d = QNAN;
          end else if (a_inf) begin
            q_d = {fa.sign ^ fb.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (b_inf || a_zero) begin
            q_d = {fa.sign ^ fb.sign, {(EXP_W+MAN_W){1'b0}}};
          end else if (b_zero) begin
            q_d   = {fa.sign ^ fb.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            dbz_d = 1'b1;
          end else begin
            exp_d   = {2'b00, fa.expo} - {2'b00, fb.expo} + 10'(BIAS);
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        if (core_done) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        state_d = S_DONE;
        if (exp_n >= $signed(10'(INF_EXP))) begin
          q_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (exp_n <= 10'sd0) begin
          q_d   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
          unf_d = 1'b1;
        end else begin
          q_d = {sign_q, exp_n[EXP_W-1:0], man_n};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
    end
  end

  assign q           = q_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_fp_divider.sv
// Directed vector bench for fp_divider: values, flags, latency, backpressure, mid-divide reset.
// Latency: checks 27 cycles for normal operands and 1 cycle for specials.
// Backpressure: holds out_ready low for 10 cycles in one sequence.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, div_by_zero, overflow, underflow;
  logic [31:0] q;

  int total = 0;
  int bad   = 0;

  fp_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] vq;
    logic [2:0]  flg;   // {div_by_zero, overflow, underflow}
    int          lat;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {29'd0, div_by_zero, overflow, underflow};
  endfunction

  // Wait (bounded) for in_ready, present operands, return just after the accept edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // Count cycles from the accept cycle (index 0) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_flags_clear"}, flags_now(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{"6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 27};
    vecs[1]  = '{"1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 27};
    vecs[2]  = '{"-1/0",       32'hBF800000, 32'h00000000, 32'hFF800000, 3'b100, 1};
    vecs[3]  = '{"0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 1};
    vecs[4]  = '{"ovf",        32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b010, 27};
    vecs[5]  = '{"unf",        32'h00800000, 32'h40000000, 32'h00000000, 3'b001, 27};
    vecs[6]  = '{"-6/2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 27};
    vecs[7]  = '{"2/4",        32'h40000000, 32'h40800000, 32'h3F000000, 3'b000, 27};
    vecs[8]  = '{"nan/1",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b000, 1};
    vecs[9]  = '{"inf/-inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000, 1};
    vecs[10] = '{"-inf/2",     32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1};
    vecs[11] = '{"2/-inf",     32'h40000000, 32'hFF800000, 32'h80000000, 3'b000, 1};
    vecs[12] = '{"-0/5",       32'h80000000, 32'h40A00000, 32'h80000000, 3'b000, 1};
    vecs[13] = '{"denorm/1",   32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 1};
    vecs[14] = '{"1/-1.5",     32'h3F800000, 32'hBFC00000, 32'hBF2AAAAA, 3'b000, 27};
    vecs[15] = '{"neg_ovf",    32'hFF000000, 32'h3E800000, 32'hFF800000, 3'b010, 27};
    vecs[16] = '{"1/1",        32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 27};
    vecs[17] = '{"unf_deep",   32'h00800000, 32'h7F000000, 32'h00000000, 3'b001, 27};
    vecs[18] = '{"unf_norm",   32'h00800000, 32'h3FC00000, 32'h00000000, 3'b001, 27};
    vecs[19] = '{"min_normal", 32'h00C00000, 32'h3F800000, 32'h00C00000, 3'b000, 27};
    vecs[20] = '{"max_finite", 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000, 27};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", q, 32'h0);
    chk("rst_flags", flags_now(), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 21; i++) begin
      issue(vecs[i].va, vecs[i].vb);
      wait_out(lat);
      chk({vecs[i].name, "_q"}, q, vecs[i].vq);
      chk({vecs[i].name, "_flags"}, flags_now(), {29'd0, vecs[i].flg});
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, "_busy"}, 32'(in_ready), 32'd0);
      finish_op(vecs[i].name);
    end

    // Backpressure: result held for 10 cycles with a competing request pending
    issue(32'h7F000000, 32'h3E800000);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd27);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_q", q, 32'h7F800000);
      chk("bp_flags", flags_now(), 32'd2);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    finish_op("bp");

    // Reset pulsed mid-divide (counter at 12): operation discarded
    issue(32'h40C00000, 32'h40000000);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready_low", 32'(in_ready), 32'd0);
    chk("mrst_flags", flags_now(), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 35; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_output", 32'(seen), 32'd0);
    issue(32'h40C00000, 32'h40000000);
    wait_out(lat);
    chk("mrst_after_q", q, 32'h40400000);
    chk("mrst_after_latency", 32'(lat), 32'd27);
    finish_op("mrst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
